motor_offset_mixer: RTL and testbench
=====================================

// Module: motor_offset_mixer
// PURPOSE
//  Parametrised successor to thro_offset_gen. Maps the received throttle value onto N motor
//  offsets, applying a signed per-motor trim with saturation and per-cycle slew limiting.
//  Offsets are gated by an arm/disarm state machine. Sits between the RC receiver decoder
//  and the per-motor PWM generators.
// PARAMETERS
//  N_MOTORS   4   number of motor channels
//  W          8   throttle and offset width (unsigned)
//  TRIM_W     6   per-motor trim width (signed, two's complement)
//  SLEW_STEP  4   maximum change of an offset per clock, in LSBs (1 .. 2^W-1)
//  ARM_HOLD   16  consecutive valid zero-throttle samples required to arm (>=1)
// PORTS
//  clk            in   1              system clock, all logic rising-edge
//  rst_n          in   1              asynchronous active-low reset
//  thro_rec_val   in   W              received throttle, unsigned
//  thro_valid     in   1              one-cycle strobe: thro_rec_val is a new sample
//  arm_req        in   1              level: 1 = pilot requests armed, 0 = disarm
//  trim_in        in   N_MOTORS*TRIM_W  signed trims, motor i at [i*TRIM_W +: TRIM_W]
//  motor_offset   out  N_MOTORS*W     slewed offsets, motor i at [i*W +: W]
//  offset_settled out  1              1 when every motor_offset equals its target
//  armed          out  1              1 in state ARMED
// BEHAVIOUR
//  Reset (async, rst_n=0): state=DISARMED, arm counter=0, targets=0, motor_offset=0,
//   offset_settled=1, armed=0. Reset mid-ramp forces outputs to 0 at once; no ramp.
//  FSM states: DISARMED, ARMING, ARMED, RAMP_DOWN.
//   DISARMED -> ARMING: arm_req=1 and thro_valid with thro_rec_val==0 (counter=1).
//   ARMING: each further valid zero sample increments the counter. A valid nonzero sample,
//    or arm_req=0, returns to DISARMED and clears the counter. When the counter
//    reaches ARM_HOLD, move to ARMED. ARM_HOLD=1 arms on the first qualifying sample.
//   ARMED -> RAMP_DOWN: arm_req=0 (sampled every clock).
//   RAMP_DOWN: targets forced to 0. Enter DISARMED on the first clock where all offsets
//    are 0. arm_req reasserting during RAMP_DOWN is ignored; rearming requires DISARMED.
//  Targets are registered, so latency is 1 clock from a thro_valid to the target update.
//   Update happens only on a thro_valid clock in ARMED.
//   target_i = 0 if thro_rec_val==0, else sat(thro + sext(trim_i)) to [0, 2^W-1].
//   Compute the sum in W+2 bits signed. trim_in is sampled on the same thro_valid.
//   Outside ARMED, targets = 0.
//  Slew: every clock, for each i, diff = target_i - motor_offset_i.
//   If |diff| <= SLEW_STEP, offset = target. Otherwise offset moves SLEW_STEP toward target.
//   No wrap-around past 0 or 2^W-1.
//   An offset begins moving the clock after its target changes.
//  offset_settled is registered. It equals the AND over i of (motor_offset_i == target_i)
//   for the next-state values.
//  Simultaneous events: arm_req falling on a thro_valid clock in ARMED gives RAMP_DOWN.
//   That sample is discarded.
//  The armed output is registered and changes on the clock the state changes.
// STRUCTURE
//  Shared package drone_pkg:
//   - state enum localparams (DISARMED=2'd0, ARMING=2'd1, ARMED=2'd2, RAMP_DOWN=2'd3)
//   - sat_add and slew_step helper functions
//  Sub-module motor_slew_chan: one channel holding target register, saturating add and
//   slew logic, with ports clk, rst_n, load, force_zero, thro, trim, offset, settled.
//  The top level holds the FSM and arm counter and instantiates N_MOTORS channels via
//   generate.
// TESTING (defaults unless stated)
//  1 Arm: arm_req=1, 16 valid thro=0 samples -> armed rises 1 clk after the 16th.
//    15 samples then thro=5 -> stays DISARMED.
//  2 Ramp-up: armed, thro=40, trims 0 -> each offset goes 0,4,8..40.
//    40 reached 10 clks after the target load; offset_settled=1 on that clock.
//  3 Saturation: thro=250, trim=+31 -> target 255. thro=10, trim=-32 -> target 0.
//    thro=1, trim=-1 -> 0. Steps of 3 or less jump directly to target.
//  4 Disarm: at offset 40 drop arm_req -> armed=0 next clk, offsets 36..0.
//    DISARMED 1 clk after reaching 0. thro_valid during ramp is ignored.
//  5 Reset mid-ramp: rst_n low at offset 20 -> outputs 0 asynchronously, state DISARMED.
//  6 Param sweep: N_MOTORS=6, W=10, SLEW_STEP=1 -> channel slicing correct.
//    thro=1023 trim=+5 saturates at 1023. Compare against a behavioural model each clock.

Source files
------------

// File: rtl/drone_pkg.sv
// ============================================================================
//  Module      : drone_pkg
//  Description : Shared definitions for the motor offset mixer. Holds the
//                arm/disarm state encoding and the arithmetic helpers used by
//                every motor channel: saturating throttle+trim add and a
//                single-clock slew-limited step toward a target.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package drone_pkg;

    typedef enum logic [1:0] {
        DISARMED  = 2'd0,
        ARMING    = 2'd1,
        ARMED     = 2'd2,
        RAMP_DOWN = 2'd3
    } arm_state_t;

    // Throttle plus signed trim, clamped to [0, max_val]. Operands arrive
    // already extended to 32 bits (unsigned throttle zero-extended, trim
    // sign-extended), so the sum cannot overflow for any practical width.
    function automatic int sat_add(input int thro, input int trim, input int max_val);
        int sum;
        int res;
        sum = thro + trim;
        if (sum < 0) begin
            res = 0;
        end else if (sum > max_val) begin
            res = max_val;
        end else begin
            res = sum;
        end
        return res;
    endfunction

    // Move cur toward tgt by at most step. Because tgt is always inside the
    // legal range and the step never overshoots it, the result cannot wrap.
    function automatic int slew_step(input int cur, input int tgt, input int step);
        int diff;
        int res;
        diff = tgt - cur;
        if (diff > step) begin
            res = cur + step;
        end else if (diff < -step) begin
            res = cur - step;
        end else begin
            res = tgt;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/motor_slew_chan.sv
// ============================================================================
//  Module      : motor_slew_chan
//  Description : One motor channel. Registers a target (throttle + trim,
//                saturated) and slews the output offset toward it by at most
//                SLEW_STEP LSBs per clock.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         in   1        system clock
//    rst_n       in   1        asynchronous active-low reset
//    load        in   1        capture a new target from thro/trim this clock
//    force_zero  in   1        drive the target to 0 (overrides load)
//    thro        in   W        throttle sample, unsigned
//    trim        in   TRIM_W   per-motor trim, signed
//    offset      out  W        slewed offset
//    settled     out  1        next offset equals next target (combinational)
// ============================================================================
`default_nettype none

module motor_slew_chan
    import drone_pkg::*;
#(
    parameter int W         = 8,
    parameter int TRIM_W    = 6,
    parameter int SLEW_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              force_zero,
    input  logic [W-1:0]      thro,
    input  logic [TRIM_W-1:0] trim,
    output logic [W-1:0]      offset,
    output logic              settled
);

    localparam int c_MAX_VAL = (1 << W) - 1;

    logic [W-1:0] r_target;
    logic [W-1:0] r_offset;
    logic [W-1:0] w_target_nxt;
    logic [W-1:0] w_offset_nxt;

    always_comb begin
        w_target_nxt = r_target;
        if (force_zero) begin
            w_target_nxt = '0;
        end else if (load) begin
            // A zero throttle always means motors off, whatever the trim.
            if (thro == '0) begin
                w_target_nxt = '0;
            end else begin
                w_target_nxt = W'(sat_add(int'(thro), int'($signed(trim)), c_MAX_VAL));
            end
        end
    end

    // The offset chases the currently registered target, so it starts moving
    // the clock after a target update.
    assign w_offset_nxt = W'(slew_step(int'(r_offset), int'(r_target), SLEW_STEP));
    assign settled      = (w_offset_nxt == w_target_nxt);
    assign offset       = r_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
            r_offset <= '0;
        end else begin
            r_target <= w_target_nxt;
            r_offset <= w_offset_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/motor_offset_mixer.sv
// ============================================================================
//  Module      : motor_offset_mixer
//  Description : Maps the received throttle onto N_MOTORS slew-limited motor
//                offsets with signed per-motor trim, gated by an arm/disarm
//                state machine.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk             in   1                  system clock
//    rst_n           in   1                  asynchronous active-low reset
//    thro_rec_val    in   W                  received throttle, unsigned
//    thro_valid      in   1                  strobe: thro_rec_val is a new sample
//    arm_req         in   1                  level: 1 = armed requested
//    trim_in         in   N_MOTORS*TRIM_W    signed trims, motor i at [i*TRIM_W +: TRIM_W]
//    motor_offset    out  N_MOTORS*W         slewed offsets, motor i at [i*W +: W]
//    offset_settled  out  1                  every offset equals its target
//    armed           out  1                  state is ARMED
// ============================================================================
`default_nettype none

module motor_offset_mixer
    import drone_pkg::*;
#(
    parameter int N_MOTORS  = 4,
    parameter int W         = 8,
    parameter int TRIM_W    = 6,
    parameter int SLEW_STEP = 4,
    parameter int ARM_HOLD  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W-1:0]               thro_rec_val,
    input  logic                       thro_valid,
    input  logic                       arm_req,
    input  logic [N_MOTORS*TRIM_W-1:0] trim_in,
    output logic [N_MOTORS*W-1:0]      motor_offset,
    output logic                       offset_settled,
    output logic                       armed
);

    localparam int c_CNT_W = $clog2(ARM_HOLD + 1);

    arm_state_t           r_state;
    arm_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]   r_arm_cnt;
    logic [c_CNT_W-1:0]   w_arm_cnt_nxt;
    logic                 r_armed;
    logic                 r_settled;

    logic                 w_zero_sample;
    logic                 w_nonzero_sample;
    logic                 w_all_zero;
    logic                 w_load;
    logic                 w_force_zero;
    logic [N_MOTORS-1:0]  w_chan_settled;

    assign w_zero_sample    = thro_valid && (thro_rec_val == '0);
    assign w_nonzero_sample = thro_valid && (thro_rec_val != '0);
    assign w_all_zero       = (motor_offset == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        case (r_state)
            DISARMED: begin
                if (arm_req && w_zero_sample) begin
                    if (ARM_HOLD == 1) begin
                        w_state_nxt   = ARMED;
                        w_arm_cnt_nxt = '0;
                    end else begin
                        w_state_nxt   = ARMING;
                        w_arm_cnt_nxt = c_CNT_W'(1);
                    end
                end
            end
            ARMING: begin
                if (!arm_req || w_nonzero_sample) begin
                    w_state_nxt   = DISARMED;
                    w_arm_cnt_nxt = '0;
                end else if (w_zero_sample) begin
                    if ((r_arm_cnt + c_CNT_W'(1)) == c_CNT_W'(ARM_HOLD)) begin
                        w_state_nxt   = ARMED;
                        w_arm_cnt_nxt = '0;
                    end else begin
                        w_arm_cnt_nxt = r_arm_cnt + c_CNT_W'(1);
                    end
                end
            end
            ARMED: begin
                if (!arm_req) begin
                    w_state_nxt = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                // arm_req is deliberately ignored here; rearming must start
                // from DISARMED once the motors have fully spun down.
                if (w_all_zero) begin
                    w_state_nxt = DISARMED;
                end
            end
            default: begin
                w_state_nxt   = DISARMED;
                w_arm_cnt_nxt = '0;
            end
        endcase
    end

    // A sample arriving on the clock that arm_req drops is discarded because
    // the next state is no longer ARMED.
    assign w_load       = (r_state == ARMED) && (w_state_nxt == ARMED) && thro_valid;
    assign w_force_zero = (w_state_nxt != ARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= DISARMED;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
            r_settled <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_cnt_nxt;
            r_armed   <= (w_state_nxt == ARMED);
            r_settled <= &w_chan_settled;
        end
    end

    assign armed          = r_armed;
    assign offset_settled = r_settled;

    for (genvar g = 0; g < N_MOTORS; g++) begin : g_chan
        motor_slew_chan #(
            .W         (W),
            .TRIM_W    (TRIM_W),
            .SLEW_STEP (SLEW_STEP)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (w_load),
            .force_zero (w_force_zero),
            .thro       (thro_rec_val),
            .trim       (trim_in[g*TRIM_W +: TRIM_W]),
            .offset     (motor_offset[g*W +: W]),
            .settled    (w_chan_settled[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_motor_offset_mixer.sv
// ============================================================================
//  Module      : tb_motor_offset_mixer
//  Description : Scoreboard bench for motor_offset_mixer. Two instances: the
//                default configuration and a wide one (6 motors, 10 bits,
//                slew 1, arm on first qualifying sample).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_motor_offset_mixer;

    localparam int S_DIS = 0;
    localparam int S_ARMING = 1;
    localparam int S_ARMED = 2;
    localparam int S_RAMP = 3;

    localparam int P_N    [2] = '{4, 6};
    localparam int P_W    [2] = '{8, 10};
    localparam int P_STEP [2] = '{4, 1};
    localparam int P_HOLD [2] = '{16, 1};

    typedef struct packed {
        logic            armed;
        logic            settled;
        logic [5:0][15:0] off;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  thro0;
    logic [9:0]  thro1;
    logic        valid0, valid1, arm0, arm1;
    logic [23:0] trim0;
    logic [35:0] trim1;
    logic [31:0] off0;
    logic [59:0] off1;
    logic        settled0, settled1, armed0, armed1;

    // Bench-side input variables, packed onto the DUT ports below.
    int a_thro  [2];
    bit a_valid [2];
    bit a_arm   [2];
    int a_trim  [2][6];

    // Reference model state.
    int m_state [2];
    int m_cnt   [2];
    int m_tgt   [2][6];
    int m_off   [2][6];

    exp_t q0[$];
    exp_t q1[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always_comb begin
        thro0  = 8'(a_thro[0]);
        thro1  = 10'(a_thro[1]);
        valid0 = a_valid[0];
        valid1 = a_valid[1];
        arm0   = a_arm[0];
        arm1   = a_arm[1];
        trim0  = '0;
        trim1  = '0;
        for (int m = 0; m < 4; m++) trim0[m*6 +: 6] = 6'(a_trim[0][m]);
        for (int m = 0; m < 6; m++) trim1[m*6 +: 6] = 6'(a_trim[1][m]);
    end

    motor_offset_mixer #(
        .N_MOTORS(4), .W(8), .TRIM_W(6), .SLEW_STEP(4), .ARM_HOLD(16)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .thro_rec_val(thro0), .thro_valid(valid0),
        .arm_req(arm0), .trim_in(trim0), .motor_offset(off0),
        .offset_settled(settled0), .armed(armed0)
    );

    motor_offset_mixer #(
        .N_MOTORS(6), .W(10), .TRIM_W(6), .SLEW_STEP(1), .ARM_HOLD(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .thro_rec_val(thro1), .thro_valid(valid1),
        .arm_req(arm1), .trim_in(trim1), .motor_offset(off1),
        .offset_settled(settled1), .armed(armed1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // One clock of the behavioural model for instance d, using the inputs
    // that are about to be sampled. Pushes the expected post-edge outputs.
    task automatic model_step(input int d);
        exp_t e;
        int   ns;
        bit   allz;
        int   lim;
        int   n;
        int   diff;
        n   = P_N[d];
        lim = (1 << P_W[d]) - 1;
        if (!rst_n) begin
            m_state[d] = S_DIS;
            m_cnt[d]   = 0;
            for (int m = 0; m < 6; m++) begin
                m_tgt[d][m] = 0;
                m_off[d][m] = 0;
            end
        end else begin
            allz = 1'b1;
            for (int m = 0; m < n; m++) if (m_off[d][m] != 0) allz = 1'b0;
            ns = m_state[d];
            if (m_state[d] == S_DIS) begin
                if (a_arm[d] && a_valid[d] && a_thro[d] == 0) begin
                    m_cnt[d] = 1;
                    ns = (m_cnt[d] >= P_HOLD[d]) ? S_ARMED : S_ARMING;
                end
            end else if (m_state[d] == S_ARMING) begin
                if (!a_arm[d] || (a_valid[d] && a_thro[d] != 0)) begin
                    ns = S_DIS;
                    m_cnt[d] = 0;
                end else if (a_valid[d]) begin
                    m_cnt[d]++;
                    if (m_cnt[d] >= P_HOLD[d]) ns = S_ARMED;
                end
            end else if (m_state[d] == S_ARMED) begin
                if (!a_arm[d]) ns = S_RAMP;
            end else begin
                if (allz) ns = S_DIS;
            end
            for (int m = 0; m < n; m++) begin
                diff = m_tgt[d][m] - m_off[d][m];
                if (diff > P_STEP[d])       m_off[d][m] += P_STEP[d];
                else if (diff < -P_STEP[d]) m_off[d][m] -= P_STEP[d];
                else                        m_off[d][m] = m_tgt[d][m];
            end
            for (int m = 0; m < n; m++) begin
                if (ns != S_ARMED) m_tgt[d][m] = 0;
                else if (m_state[d] == S_ARMED && a_valid[d])
                    m_tgt[d][m] = (a_thro[d] == 0) ? 0 : clamp(a_thro[d] + a_trim[d][m], 0, lim);
            end
            m_state[d] = ns;
        end
        e = '0;
        e.armed   = (m_state[d] == S_ARMED);
        e.settled = 1'b1;
        for (int m = 0; m < n; m++) begin
            if (m_off[d][m] != m_tgt[d][m]) e.settled = 1'b0;
            e.off[m] = 16'(m_off[d][m]);
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check_dut(input int d, input exp_t e);
        int act;
        chk($sformatf("d%0d_armed", d), (d == 0) ? int'(armed0) : int'(armed1), int'(e.armed));
        chk($sformatf("d%0d_settled", d), (d == 0) ? int'(settled0) : int'(settled1), int'(e.settled));
        for (int m = 0; m < P_N[d]; m++) begin
            if (d == 0) act = int'(off0[m*8 +: 8]);
            else        act = int'(off1[m*10 +: 10]);
            chk($sformatf("d%0d_offset%0d", d, m), act, int'(e.off[m]));
        end
    endtask

    // Monitor: every clock the DUTs present a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_dut(0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_dut(1, e);
            end
        end
    end

    // Called in the low phase with inputs set; returns at the next negedge.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic sample(input int d, input int thro);
        a_valid[d] = 1'b1;
        a_thro[d]  = thro;
        tick();
        a_valid[d] = 1'b0;
    endtask

    task automatic set_trims(input int d, input int t0, input int t1, input int t2,
                             input int t3, input int t4, input int t5);
        a_trim[d][0] = t0; a_trim[d][1] = t1; a_trim[d][2] = t2;
        a_trim[d][3] = t3; a_trim[d][4] = t4; a_trim[d][5] = t5;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            a_thro[d] = 0; a_valid[d] = 1'b0; a_arm[d] = 1'b0;
            set_trims(d, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Arming qualification: 15 zeros then a nonzero aborts; arm_req drop aborts.
        a_arm[0] = 1'b1;
        repeat (15) sample(0, 0);
        sample(0, 5);
        tick();
        repeat (3) sample(0, 0);
        a_arm[0] = 1'b0;
        tick();
        a_arm[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sample(0, 0);
            if (i % 5 == 2) tick();
        end
        tick();

        // Ramp up to 40, then small steps that jump directly.
        sample(0, 40);
        repeat (12) tick();
        sample(0, 43);
        tick();
        sample(0, 40);
        tick();

        // Saturation at both ends and the thro=1/trim=-1 case.
        set_trims(0, 31, -32, -1, 3, 0, 0);
        sample(0, 250);
        repeat (66) tick();
        set_trims(0, -32, -1, 31, 0, 0, 0);
        sample(0, 10);
        repeat (66) tick();
        set_trims(0, -1, -1, 0, 1, 0, 0);
        sample(0, 1);
        repeat (6) tick();

        // Disarm from offset 40; samples during the ramp-down are ignored.
        set_trims(0, 0, 0, 0, 0, 0, 0);
        sample(0, 40);
        repeat (12) tick();
        a_arm[0] = 1'b0;
        a_valid[0] = 1'b1;
        a_thro[0] = 200;
        tick();
        a_valid[0] = 1'b0;
        tick();
        sample(0, 100);
        a_arm[0] = 1'b1;
        repeat (14) tick();

        // Re-arm, ramp to 20 then reset asynchronously.
        repeat (16) sample(0, 0);
        sample(0, 40);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_armed", int'(armed0), 0);
        chk("async_rst_settled", int'(settled0), 1);
        chk("async_rst_offsets", int'(off0), 0);
        tick();
        rst_n = 1'b1;
        a_arm[0] = 1'b0;
        tick();

        // Wide instance: arms on one sample, full-scale saturation, per-channel slicing.
        a_arm[1] = 1'b1;
        sample(1, 0);
        set_trims(1, 5, -3, 0, -32, 31, 1);
        sample(1, 1023);
        repeat (1030) tick();
        set_trims(1, 1, 2, 3, 4, 5, 6);
        sample(1, 7);
        repeat (40) tick();

        // Randomised traffic on both instances.
        a_arm[0] = 1'b1;
        repeat (16) sample(0, 0);
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                a_arm[d]   = ($urandom_range(99) < 97);
                a_valid[d] = ($urandom_range(99) < 30);
                a_thro[d]  = ($urandom_range(99) < 20) ? 0
                             : int'($urandom_range((d == 0) ? 255 : 60));
                for (int m = 0; m < 6; m++) a_trim[d][m] = int'($urandom_range(63)) - 32;
            end
            tick();
        end
        a_valid[0] = 1'b0;
        a_valid[1] = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
